// File: rtl/ble_tx_pkg.sv
// Shared constants and types for the BLE bit-serial TX path.
// CRC-24 polynomial, whitening taps and the CRC/whitening FSM state type.
package ble_tx_pkg;

  localparam int CRC_WIDTH = 24;
  localparam logic [CRC_WIDTH-1:0] CRC_POLY = 24'h00065B;

  localparam int WHITEN_WIDTH = 7;
  // old[6] feeds pos0 and is XORed into pos4
  localparam logic [WHITEN_WIDTH-1:0] WHITEN_FB_MASK = 7'b0010000;

  typedef enum logic [1:0] {
    Idle,
    Data,
    Crc,
    Drain
  } crc_wh_state_t;

  function automatic logic [CRC_WIDTH-1:0] crc_step(
    input logic [CRC_WIDTH-1:0] c,
    input logic                 d
  );
    logic fb;
    fb = c[CRC_WIDTH-1] ^ d;
    return {c[CRC_WIDTH-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
  endfunction

endpackage

// File: rtl/ble_whitening_lfsr.sv
// BLE data whitening LFSR (x^7 + x^4 + 1), seeded from the RF channel.
// Position 0 is forced to 1 on load; channel[5] lands in position 1.
module ble_whitening_lfsr
  import ble_tx_pkg::*;
(
  input  logic       aclk,
  input  logic       areset,
  input  logic       load,
  input  logic [5:0] channel,
  input  logic       step,
  output logic       bit_out
);

  logic [WHITEN_WIDTH-1:0] lfsr;

  assign bit_out = lfsr[WHITEN_WIDTH-1];

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      lfsr <= '0;
    end else if (load) begin
      lfsr <= {channel[0], channel[1], channel[2],
               channel[3], channel[4], channel[5], 1'b1};
    end else if (step) begin
      lfsr <= {lfsr[WHITEN_WIDTH-2:0], lfsr[WHITEN_WIDTH-1]}
            ^ ({WHITEN_WIDTH{lfsr[WHITEN_WIDTH-1]}} & WHITEN_FB_MASK);
    end
  end

endmodule

// File: rtl/crc_whitening_generator.sv
// Bit-serial BLE CRC-24 append and channel whitening stage.
// One output register; the trailer follows the last PDU bit with no bubble.
module crc_whitening_generator
  import ble_tx_pkg::*;
(
  input  logic                 aclk,
  input  logic                 areset,
  input  logic                 restart,
  input  logic [CRC_WIDTH-1:0] crc_init,
  input  logic [5:0]           channel,
  input  logic                 whitening_en,
  input  logic                 input_tdata,
  input  logic                 input_tvalid,
  output logic                 input_tready,
  input  logic                 input_tlast,
  output logic                 output_tdata,
  output logic                 output_tvalid,
  input  logic                 output_tready,
  output logic                 output_tlast
);

  crc_wh_state_t        state;
  logic [CRC_WIDTH-1:0] crc;
  logic [4:0]           counter;
  logic                 wen;
  logic                 w_raw;
  logic                 w;
  logic                 slot_free;
  logic                 in_hs;
  logic                 out_hs;
  logic                 emit;

  assign slot_free    = ~output_tvalid | output_tready;
  assign input_tready = (state == Data) & slot_free;
  assign in_hs        = input_tvalid & input_tready;
  assign out_hs       = output_tvalid & output_tready;
  assign w            = wen & w_raw;
  // whitening advances only on bits that actually enter the output register
  assign emit = ~restart & (in_hs | ((state == Crc) & slot_free));

  ble_whitening_lfsr u_lfsr (
    .aclk    (aclk),
    .areset  (areset),
    .load    (restart),
    .channel (channel),
    .step    (emit),
    .bit_out (w_raw)
  );

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state         <= Idle;
      crc           <= '0;
      counter       <= '0;
      wen           <= 1'b0;
      output_tdata  <= 1'b0;
      output_tvalid <= 1'b0;
      output_tlast  <= 1'b0;
    end else if (restart) begin
      crc           <= crc_init;
      wen           <= whitening_en;
      counter       <= '0;
      output_tvalid <= 1'b0;
      output_tlast  <= 1'b0;
      state         <= Data;
    end else begin
      unique case (state)
        Idle: begin
          if (out_hs) output_tvalid <= 1'b0;
        end
        Data: begin
          if (in_hs) begin
            output_tdata  <= input_tdata ^ w;
            output_tvalid <= 1'b1;
            output_tlast  <= 1'b0;
            crc           <= crc_step(crc, input_tdata);
            if (input_tlast) state <= Crc;
          end else if (out_hs) begin
            output_tvalid <= 1'b0;
          end
        end
        Crc: begin
          if (slot_free) begin
            output_tdata  <= crc[CRC_WIDTH-1] ^ w;
            output_tvalid <= 1'b1;
            crc           <= {crc[CRC_WIDTH-2:0], 1'b0};
            counter       <= counter + 5'd1;
            if (counter == 5'(CRC_WIDTH - 1)) begin
              output_tlast <= 1'b1;
              state        <= Drain;
            end
          end
        end
        Drain: begin
          if (out_hs && output_tlast) begin
            output_tvalid <= 1'b0;
            output_tlast  <= 1'b0;
            state         <= Idle;
          end
        end
        default: state <= Idle;
      endcase
    end
  end

endmodule

// File: tb/tb_crc_whitening_generator.sv
// Scoreboard bench for crc_whitening_generator.
// Stimulus pushes expected {bit,last}; a negedge monitor pops and compares.
module tb_crc_whitening_generator;

  logic        aclk;
  logic        areset;
  logic        restart;
  logic [23:0] crc_init;
  logic [5:0]  channel;
  logic        whitening_en;
  logic        input_tdata;
  logic        input_tvalid;
  logic        input_tready;
  logic        input_tlast;
  logic        output_tdata;
  logic        output_tvalid;
  logic        output_tready;
  logic        output_tlast;

  crc_whitening_generator dut (
    .aclk          (aclk),
    .areset        (areset),
    .restart       (restart),
    .crc_init      (crc_init),
    .channel       (channel),
    .whitening_en  (whitening_en),
    .input_tdata   (input_tdata),
    .input_tvalid  (input_tvalid),
    .input_tready  (input_tready),
    .input_tlast   (input_tlast),
    .output_tdata  (output_tdata),
    .output_tvalid (output_tvalid),
    .output_tready (output_tready),
    .output_tlast  (output_tlast)
  );

  int         n_cmp = 0;
  int         n_err = 0;
  logic [1:0] exp_q[$];
  logic       toggle_mode = 1'b0;
  logic       tready_hold = 1'b1;
  logic [3:0] pat = 4'b1001;
  int         k = 0;

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: sim time %0t exceeded limit", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // output_tready driver: fixed level or 1,0,0,1 pattern
  initial begin
    output_tready = 1'b1;
    forever begin
      @(posedge aclk);
      #1;
      if (toggle_mode) begin
        output_tready = pat[k[1:0]];
        k = k + 1;
      end else begin
        output_tready = tready_hold;
      end
    end
  end

  // monitor
  initial begin
    logic       prev_stall;
    logic [2:0] prev_vals;
    logic [1:0] e;
    prev_stall = 1'b0;
    prev_vals  = '0;
    forever begin
      @(negedge aclk);
      if (areset) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall)
          check("stall_hold",
                32'({output_tvalid, output_tdata, output_tlast}),
                32'(prev_vals));
        if (output_tvalid && !output_tready)
          check("tready_in_stall", 32'(input_tready), 32'd0);
        if (output_tvalid && output_tready) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL extra_out: got bit %b last %b, none expected",
                     output_tdata, output_tlast);
          end else begin
            e = exp_q.pop_front();
            check("out_bit", 32'({output_tdata, output_tlast}), 32'(e));
          end
        end
        prev_stall = output_tvalid & ~output_tready;
        prev_vals  = {output_tvalid, output_tdata, output_tlast};
      end
    end
  end

  // push n bits of v MSB-first; last flag on the final one if with_last
  task automatic push_seq(input logic [31:0] v, input int n,
                          input logic with_last);
    for (int i = n - 1; i >= 0; i--)
      exp_q.push_back({v[i], with_last && (i == 0)});
  endtask

  task automatic do_restart(input logic [23:0] ci, input logic [5:0] ch,
                            input logic we);
    crc_init     = ci;
    channel      = ch;
    whitening_en = we;
    restart      = 1'b1;
    @(posedge aclk);
    #1;
    restart = 1'b0;
  endtask

  task automatic send_bit(input logic d, input logic last);
    logic got;
    int   t;
    got = 1'b0;
    t   = 0;
    input_tdata  = d;
    input_tlast  = last;
    input_tvalid = 1'b1;
    while (!got && t < 200) begin
      @(negedge aclk);
      got = input_tready;
      @(posedge aclk);
      #1;
      t++;
    end
    input_tvalid = 1'b0;
    input_tlast  = 1'b0;
    if (!got) begin
      n_cmp++;
      n_err++;
      $display("FAIL in_timeout: got no input_tready, required 1");
    end
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 300) begin
      @(posedge aclk);
      #1;
      t++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: got %0d pending, required 0",
               exp_q.size());
    end
    repeat (2) begin
      @(posedge aclk);
      #1;
    end
  endtask

  initial begin
    areset       = 1'b1;
    restart      = 1'b0;
    crc_init     = '0;
    channel      = '0;
    whitening_en = 1'b0;
    input_tdata  = 1'b0;
    input_tvalid = 1'b0;
    input_tlast  = 1'b0;

    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check("rst_tvalid", 32'(output_tvalid), 32'd0);
    check("rst_tdata", 32'(output_tdata), 32'd0);
    check("rst_tlast", 32'(output_tlast), 32'd0);
    check("rst_tready", 32'(input_tready), 32'd0);
    @(posedge aclk);
    #1;
    areset = 1'b0;
    @(posedge aclk);
    #1;

    // 1: single 0 bit, no whitening -> 25 zeros
    do_restart(24'h0, 6'd0, 1'b0);
    push_seq(32'h0, 25, 1'b1);
    send_bit(1'b0, 1'b1);
    wait_drain();
    @(negedge aclk);
    check("idle_tready", 32'(input_tready), 32'd0);
    @(posedge aclk);
    #1;
    input_tdata  = 1'b1;
    input_tvalid = 1'b1;
    repeat (5) @(posedge aclk);
    #1;
    input_tvalid = 1'b0;
    check("idle_no_accept", 32'(output_tvalid), 32'd0);

    // 2: single 1 bit -> 1 then CRC_POLY MSB-first
    do_restart(24'h0, 6'd0, 1'b0);
    push_seq(32'h0100065B, 25, 1'b1);
    send_bit(1'b1, 1'b1);
    wait_drain();

    // 4: same packet under 1,0,0,1 backpressure
    k = 0;
    toggle_mode = 1'b1;
    do_restart(24'h0, 6'd0, 1'b0);
    push_seq(32'h0100065B, 25, 1'b1);
    send_bit(1'b1, 1'b1);
    wait_drain();
    toggle_mode = 1'b0;
    @(posedge aclk);
    #1;

    // 5: restart after 10 CRC bits, then a fresh scenario-1 packet
    do_restart(24'h0, 6'd0, 1'b0);
    push_seq(32'h00000400, 11, 1'b0);
    send_bit(1'b1, 1'b1);
    repeat (10) @(posedge aclk);
    #1;
    restart = 1'b1;
    @(posedge aclk);
    #1;
    restart = 1'b0;
    @(negedge aclk);
    check("rs_tvalid", 32'(output_tvalid), 32'd0);
    check("rs_tlast", 32'(output_tlast), 32'd0);
    check("rs_data_state", 32'(input_tready), 32'd1);
    check("rs_emitted", 32'(exp_q.size()), 32'd0);
    @(posedge aclk);
    #1;
    push_seq(32'h0, 25, 1'b1);
    send_bit(1'b0, 1'b1);
    wait_drain();

    // 6: async reset with a stalled bit in the output register
    tready_hold = 1'b0;
    do_restart(24'h0, 6'd0, 1'b0);
    send_bit(1'b1, 1'b0);
    check("pre_rst_tdata", 32'(output_tdata), 32'd1);
    #2;
    areset = 1'b1;
    #1;
    check("arst_tvalid", 32'(output_tvalid), 32'd0);
    check("arst_tdata", 32'(output_tdata), 32'd0);
    check("arst_tlast", 32'(output_tlast), 32'd0);
    check("arst_tready", 32'(input_tready), 32'd0);
    @(posedge aclk);
    #1;
    areset      = 1'b0;
    tready_hold = 1'b1;
    repeat (3) begin
      @(negedge aclk);
      check("post_rst_tready", 32'(input_tready), 32'd0);
    end
    @(posedge aclk);
    #1;
    do_restart(24'h0, 6'd0, 1'b0);
    @(negedge aclk);
    check("rearm_tready", 32'(input_tready), 32'd1);
    @(posedge aclk);
    #1;

    // 3: 8 zero bits, whitening on channel 0 -> pure whitening sequence
    do_restart(24'h0, 6'd0, 1'b1);
    push_seq(32'h024D3DC3, 32, 1'b1);
    for (int i = 0; i < 8; i++) send_bit(1'b0, i == 7);
    wait_drain();

    check("final_q_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
